// File: rtl/fetch_icache_pkg.sv
// Shared LC-3b fetch types for the instruction cache: word/line types, FSM state, word select.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  localparam int OFFSET_W = 4;

  function automatic lc3b_word line_word(input lc3b_cacheline line, input logic [2:0] sel);
    return line[{sel, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped {valid, tag, line} storage: combinational read, synchronous load.
module icache_array
  import lc3b_types::*;
#(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int TAG_W    = 16 - OFFSET_W - IDX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output lc3b_cacheline      rd_line,
  input  logic               load,
  input  logic [IDX_W-1:0]   wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  lc3b_cacheline      wr_line
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  lc3b_cacheline       line_q [NUM_SETS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (load) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: a line is only visible through its valid bit.
  always_ff @(posedge clk) begin
    if (load) begin
      tag_q[wr_index]  <= wr_tag;
      line_q[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = line_q[rd_index];

endmodule

// File: rtl/fetch_icache.sv
// Read-only direct-mapped instruction cache answering the fetch stage; fills lines from pmem.
// Optional hit/miss statistics counters are enabled with the ICACHE_STATS_EN macro.
module fetch_icache
  import lc3b_types::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  lc3b_word      mem_address,
  input  logic          mem_read,
  output lc3b_word      mem_rdata,
  output logic          mem_resp,
  output lc3b_word      pmem_address,
  output logic          pmem_read,
  input  lc3b_cacheline pmem_rdata,
  input  logic          pmem_resp,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count,
  output icache_state_t state_dbg
);

  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 16 - OFFSET_W - IDX_W;
  localparam int LADR_W = 16 - OFFSET_W;

  // Handshake: fetch holds mem_read/mem_address until a one-cycle mem_resp;
  // pmem_read/pmem_address stay asserted from a flop until the cycle pmem_resp is seen.
  icache_state_t      state_q, state_d;
  logic [LADR_W-1:0]  miss_addr_q;

  logic [IDX_W-1:0]   index;
  logic [TAG_W-1:0]   tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  lc3b_cacheline      rd_line;
  logic               lookup_hit;
  logic               hit;
  logic               miss;
  logic               fill_done;
  logic               unused_addr_bit;

  assign index           = mem_address[OFFSET_W +: IDX_W];
  assign tag             = mem_address[15 -: TAG_W];
  assign unused_addr_bit = mem_address[0];

  icache_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .load     (fill_done),
    .wr_index (miss_addr_q[IDX_W-1:0]),
    .wr_tag   (miss_addr_q[LADR_W-1 -: TAG_W]),
    .wr_line  (pmem_rdata)
  );

  assign lookup_hit = rd_valid && (rd_tag == tag);
  assign hit        = (state_q == IDLE) && mem_read && lookup_hit;
  assign miss       = (state_q == IDLE) && mem_read && !lookup_hit;
  assign fill_done  = (state_q == FILL) && pmem_resp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss) begin
        miss_addr_q <= mem_address[15:OFFSET_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_address = {miss_addr_q, {OFFSET_W{1'b0}}};
    case (state_q)
      IDLE: begin
        mem_resp  = hit;
        mem_rdata = hit ? line_word(rd_line, mem_address[3:1]) : '0;
        if (miss) begin
          state_d = FILL;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_dbg = state_q;

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_q, miss_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit && (hit_q != 16'hFFFF)) begin
        hit_q <= hit_q + 16'd1;
      end
      if (miss && (miss_q != 16'hFFFF)) begin
        miss_q <= miss_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_fetch_icache.sv
// Bench for fetch_icache: directed table and corner sequences plus random traffic vs a set-map model.
module tb_fetch_icache;
  import lc3b_types::*;

  localparam int NUM_SETS = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  lc3b_word      mem_address;
  logic          mem_read;
  lc3b_word      mem_rdata;
  logic          mem_resp;
  lc3b_word      pmem_address;
  logic          pmem_read;
  lc3b_cacheline pmem_rdata;
  logic          pmem_resp;
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;
  icache_state_t state_dbg;

  always #5 clk = ~clk;

  fetch_icache #(.NUM_SETS(NUM_SETS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .state_dbg    (state_dbg)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference: memory image plus, per set, which line address is resident.
  logic [127:0] mem_img [256];
  logic [11:0]  m_line  [NUM_SETS];
  bit           m_valid [NUM_SETS];
  int           m_hits;
  int           m_misses;

  typedef struct {
    logic [15:0] addr;
    logic        exp_resp;
    logic [15:0] exp_rdata;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    logic [127:0] l;
    int w;
    l = mem_img[a[11:4]];
    w = int'(a[3:1]);
    return l[w*16 +: 16];
  endfunction

  function automatic bit ref_hit(input logic [15:0] a);
    int s;
    s = int'(a[15:4]) % NUM_SETS;
    return m_valid[s] && (m_line[s] == a[15:4]);
  endfunction

  task automatic model_install(input logic [15:0] a);
    int s;
    s = int'(a[15:4]) % NUM_SETS;
    m_valid[s] = 1'b1;
    m_line[s]  = a[15:4];
  endtask

  task automatic model_reset();
    for (int s = 0; s < NUM_SETS; s++) m_valid[s] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic check_counts(input string tag);
`ifdef ICACHE_STATS_EN
    check({tag, "_hit_count"}, hit_count, m_hits);
    check({tag, "_miss_count"}, miss_count, m_misses);
`else
    check({tag, "_hit_count"}, hit_count, 0);
    check({tag, "_miss_count"}, miss_count, 0);
`endif
  endtask

  // Entered and left at posedge+1; mem_read is left high for back-to-back use.
  task automatic do_access(input logic [15:0] addr, input logic [15:0] retry_addr, input int lat);
    mem_read    = 1'b1;
    mem_address = addr;
    if (ref_hit(addr)) begin
      @(negedge clk);
      check("hit_resp", mem_resp, 1);
      check("hit_rdata", mem_rdata, ref_word(addr));
      check("hit_no_pmem", pmem_read, 0);
      m_hits++;
      @(posedge clk); #1;
    end else begin
      @(negedge clk);
      check("miss_resp", mem_resp, 0);
      m_misses++;
      @(posedge clk); #1;
      for (int i = 0; i <= lat; i++) begin
        if (i == lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mem_img[addr[11:4]];
        end
        @(negedge clk);
        check("fill_pmem_read", pmem_read, 1);
        check("fill_pmem_addr", pmem_address, {addr[15:4], 4'h0});
        check("fill_no_resp", mem_resp, 0);
        check("fill_state", state_dbg, FILL);
        @(posedge clk); #1;
      end
      pmem_resp   = 1'b0;
      pmem_rdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
      model_install(addr);
      mem_address = retry_addr;
      @(negedge clk);
      check("retry_resp", mem_resp, 1);
      check("retry_rdata", mem_rdata, ref_word(retry_addr));
      check("retry_no_pmem", pmem_read, 0);
      m_hits++;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycle(input logic pulse_resp);
    mem_read  = 1'b0;
    pmem_resp = pulse_resp;
    @(negedge clk);
    check("idle_no_resp", mem_resp, 0);
    check("idle_no_pmem", pmem_read, 0);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [15:0] r;

    rst_n       = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    pmem_resp   = 1'b0;
    pmem_rdata  = '0;
    for (int i = 0; i < 256; i++) mem_img[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    mem_img[4] = {16'h0A77, 16'h0A66, 16'h0A55, 16'h0A44, 16'h0A33, 16'h1234, 16'h0A11, 16'h0A00};
    model_reset();

    tbl[0] = '{16'h0040, 1'b1, 16'h0A00};
    tbl[1] = '{16'h0042, 1'b1, 16'h0A11};
    tbl[2] = '{16'h0044, 1'b1, 16'h1234};
    tbl[3] = '{16'h0046, 1'b1, 16'h0A33};
    tbl[4] = '{16'h004E, 1'b1, 16'h0A77};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mem_resp", mem_resp, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_state", state_dbg, IDLE);
    check_counts("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First fill, retry with another word of the same line
    do_access(16'h0040, 16'h0044, 3);

    // Back-to-back hits across the filled line
    for (int i = 0; i < 5; i++) begin
      mem_read    = 1'b1;
      mem_address = tbl[i].addr;
      @(negedge clk);
      check("tbl_resp", mem_resp, tbl[i].exp_resp);
      check("tbl_rdata", mem_rdata, tbl[i].exp_rdata);
      check("tbl_no_pmem", pmem_read, 0);
      m_hits++;
      @(posedge clk); #1;
    end
    idle_cycle(1'b0);
    check_counts("b2b");

    // Conflict in set 4
    do_access(16'h00C0, 16'h00C0, 2);
    do_access(16'h0040, 16'h0040, 1);
    check_counts("conflict");

    // Drop mem_read and move the address while the fill is outstanding
    mem_read    = 1'b1;
    mem_address = 16'h0120;
    @(negedge clk);
    check("drop_miss_resp", mem_resp, 0);
    m_misses++;
    @(posedge clk); #1;
    mem_read    = 1'b0;
    mem_address = 16'h0300;
    for (int i = 0; i <= 2; i++) begin
      if (i == 2) begin
        pmem_resp  = 1'b1;
        pmem_rdata = mem_img[8'h12];
      end
      @(negedge clk);
      check("drop_pmem_read", pmem_read, 1);
      check("drop_pmem_addr", pmem_address, 16'h0120);
      check("drop_no_resp", mem_resp, 0);
      @(posedge clk); #1;
    end
    pmem_resp = 1'b0;
    model_install(16'h0120);
    @(negedge clk);
    check("drop_after_resp", mem_resp, 0);
    check("drop_after_pmem", pmem_read, 0);
    @(posedge clk); #1;
    do_access(16'h0126, 16'h0126, 0);
    idle_cycle(1'b0);
    check_counts("drop");

    // Reset in the middle of a fill
    mem_read    = 1'b1;
    mem_address = 16'h0200;
    @(negedge clk);
    check("rstfill_miss_resp", mem_resp, 0);
    m_misses++;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstfill_pmem_read", pmem_read, 1);
    @(posedge clk); #1;
    rst_n    = 1'b0;
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("rstfill_pmem_low", pmem_read, 0);
    check("rstfill_state", state_dbg, IDLE);
    check_counts("rstfill");
    @(posedge clk); #1;
    pmem_resp  = 1'b1;
    pmem_rdata = mem_img[8'h20];
    @(negedge clk);
    check("late_resp_pmem", pmem_read, 0);
    check("late_resp_resp", mem_resp, 0);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    do_access(16'h0200, 16'h0200, 1);
    do_access(16'h0126, 16'h0126, 2);
    idle_cycle(1'b0);

    // Random traffic, stray pmem_resp pulses in IDLE
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle_cycle(1'($urandom_range(0, 1)));
      end else begin
        a = 16'($urandom_range(0, 16'h03FE)) & 16'hFFFE;
        r = {a[15:4], 3'($urandom_range(0, 7)), 1'b0};
        do_access(a, r, $urandom_range(0, 4));
      end
    end
    idle_cycle(1'b0);
    check_counts("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
